fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage between the instruction port of the memory and the cpu decoder.
//  Drives i_addr and absorbs the memory's one-cycle synchronous read latency.
//  Buffers fetched words in a DEPTH-entry FIFO and pairs literal-carrying instructions with the following word.
//  Presents one complete instruction at a time on a valid/ready handshake and accepts pc redirects from execute.
// PARAMETERS
//  DEPTH      4        FIFO entries, minimum 2; a literal pair must fit.
//  RESET_PC   16'h0000 First fetch address after reset.
//  LIT_MASK   16'h00FF Bits compared to detect a literal-carrying instruction.
//  LIT_MATCH  16'h001A Word is literal-carrying iff (word & LIT_MASK) == LIT_MATCH.
// PORTS
//  clk          in   1   Single clock; all state updates on posedge.
//  rst          in   1   Synchronous reset, active-high.
//  i_addr       out  16  Fetch address, registered; memory samples it every posedge.
//  i_bus        in   16  mem[i_addr as sampled at the previous posedge].
//  redirect     in   1   Flush and restart fetch at redirect_pc.
//  redirect_pc  in   16  New fetch address, used when redirect=1.
//  out_valid    out  1   out_* hold a complete instruction.
//  out_ready    in   1   Decoder accepts the instruction when out_valid & out_ready.
//  out_instr    out  16  Instruction word.
//  out_literal  out  16  Following word if out_has_lit=1, else 16'h0000.
//  out_has_lit  out  1   Instruction is literal-carrying.
//  out_pc       out  16  Address of out_instr.
// BEHAVIOUR
//  Reset: i_addr=RESET_PC, FIFO empty (count=0), inflight=0, out_valid=0, out_instr/out_literal/out_pc=0, out_has_lit=0.
//  Issue: at each non-reset, non-redirect posedge, memory samples i_addr.
//   - pop_n = 0, 1 or 2 words consumed by a handshake this cycle.
//   - issue_ok = (count + inflight - pop_n) < DEPTH.
//   - issue_ok=1: inflight<=1, inflight_pc<=i_addr, i_addr<=i_addr+1 (16-bit wrap, FFFF -> 0000).
//   - issue_ok=0: inflight<=0, i_addr holds, sampled word discarded. FIFO never overflows.
//  Capture: if inflight=1, push {i_bus, inflight_pc} into FIFO at the next posedge.
//  Output, combinational from FIFO head entries only; no combinational path from out_ready to out_valid:
//   - head not literal-carrying: out_valid = (count>=1).
//   - head literal-carrying: out_valid = (count>=2); out_literal = entry 2 word.
//   - Handshake pops 1 word (plain) or 2 words (literal pair) at that posedge.
//  Literal pair straddling FFFF/0000: literal taken from 0000; out_pc=FFFF.
//  Throughput: with out_ready held 1, one word per cycle is sustained; a literal pair takes two cycles.
//  Redirect at posedge N (redirect=1, rst=0):
//   - FIFO cleared, inflight<=0, i_addr<=redirect_pc.
//   - out_valid forced 0 during the redirect cycle, so no handshake occurs then.
//   - Memory samples redirect_pc at N+1; word captured at N+2; out_valid rises after N+2 if plain.
//  Simultaneous rst and redirect: rst wins.
//  Simultaneous push and pop: count updates to count + 1 - pop_n.
//  Reset mid-operation: all state returns to reset values at that posedge; in-flight word discarded.
//  Reset to first instruction: first posedge with rst=0 issues RESET_PC; a plain word reaches out_valid after the 2nd such posedge, a literal pair after the 3rd.
// TESTING
//  1. Program mem[0..4] = FF1A, AAAA, FF3A, FF3B, FF3F; out_ready=1; release rst.
//     -> Handshakes in order: (FF1A, lit AAAA, pc 0), (FF3A, pc 2), (FF3B, pc 3), (FF3F, pc 4).
//     -> First out_valid after the 3rd posedge post-reset.
//  2. Same program, out_ready=0 for 10 cycles, then 1.
//     -> count peaks at DEPTH=4 and i_addr stalls at 4 with no word lost or duplicated.
//     -> Order as in test 1.
//  3. Redirect to 0010 on the cycle after FF1A enters the FIFO, before AAAA is captured; mem[10]=1234.
//     -> FF1A never handshakes; the first handshake is 1234 at pc 0010, exactly after posedge N+2.
//  4. Redirect with the FIFO full and out_ready=0.
//     -> out_valid=0 in the redirect cycle; FIFO emptied; only words from redirect_pc appear afterwards.
//  5. Redirect to FFFF with mem[FFFF]=001A and mem[0]=5555.
//     -> Handshake (001A, lit 5555, pc FFFF); next instruction fetched from 0001.
//  6. Assert rst for one cycle while the FIFO holds 3 words.
//     -> All outputs return to reset values; fetch restarts at RESET_PC; no pre-reset word appears.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, execute redirect and decoder handshake.
// master = fetch unit, slave = memory/execute/decoder environment.
`timescale 1ns/1ps
interface fetch_unit_if;
    logic [15:0] i_addr;
    logic [15:0] i_bus;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_literal;
    logic        out_has_lit;
    logic [15:0] out_pc;

    modport master (
        output i_addr,
        input  i_bus,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_literal,
        output out_has_lit,
        output out_pc
    );

    modport slave (
        input  i_addr,
        output i_bus,
        output redirect,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_literal,
        input  out_has_lit,
        input  out_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues addresses, absorbs the one-cycle memory latency,
// buffers words in a small FIFO and hands out plain instructions or literal pairs.
`timescale 1ns/1ps
module fetch_unit #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] LIT_MASK  = 16'h00FF,
    parameter logic [15:0] LIT_MATCH = 16'h001A
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam int unsigned AW  = 16;
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW2 = PW + 2;
    localparam int unsigned CW  = $clog2(DEPTH + 2) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] word;
        logic [AW-1:0] pc;
    } entry_t;

    entry_t        fifo_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          inflight;
    logic [AW-1:0] inflight_pc;
    logic [AW-1:0] i_addr_q;

    entry_t        head;
    entry_t        second;
    logic          head_lit;
    logic          head_ready;
    logic          valid_c;
    logic          fire_c;
    logic [1:0]    pop_n;
    logic [CW-1:0] occupancy;
    logic          issue_ok;

    // Circular pointer advance that also works for non power-of-two depths.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW2-1:0] s;
        s = PW2'(p) + PW2'(n);
        if (s >= PW2'(DEPTH)) begin
            s = s - PW2'(DEPTH);
        end
        return s[PW-1:0];
    endfunction

    assign head   = fifo_mem[rd_ptr];
    assign second = fifo_mem[ptr_add(rd_ptr, 2'd1)];

    // Output and pop decision come only from FIFO head state, never from out_ready into out_valid.
    always_comb begin
        head_lit   = (head.word & LIT_MASK) == LIT_MATCH;
        head_ready = head_lit ? (count >= CW'(2)) : (count >= CW'(1));
        valid_c    = !rst && !bus.redirect && head_ready;
        fire_c     = valid_c && bus.out_ready;
        pop_n      = 2'd0;
        if (fire_c) begin
            pop_n = head_lit ? 2'd2 : 2'd1;
        end
        occupancy  = count + CW'(inflight) - CW'(pop_n);
        issue_ok   = occupancy < DEPTH_C;
    end

    assign bus.i_addr      = i_addr_q;
    assign bus.out_valid   = valid_c;
    assign bus.out_instr   = valid_c ? head.word : '0;
    assign bus.out_pc      = valid_c ? head.pc : '0;
    assign bus.out_has_lit = valid_c && head_lit;
    assign bus.out_literal = (valid_c && head_lit) ? second.word : '0;

    // Fetch control: issue, capture bookkeeping, pops, redirect flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_addr_q    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (bus.redirect) begin
            i_addr_q    <= bus.redirect_pc;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (inflight) begin
                wr_ptr <= ptr_add(wr_ptr, 2'd1);
            end
            rd_ptr <= ptr_add(rd_ptr, pop_n);
            count  <= occupancy;
            if (issue_ok) begin
                inflight    <= 1'b1;
                inflight_pc <= i_addr_q;
                i_addr_q    <= i_addr_q + 16'd1;
            end else begin
                inflight    <= 1'b0;
            end
        end
    end

    // Word returned by memory for last cycle's issue lands in the FIFO.
    always_ff @(posedge clk) begin
        if (!rst && !bus.redirect && inflight) begin
            fifo_mem[wr_ptr] <= '{word: bus.i_bus, pc: inflight_pc};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit against an instruction-stream reference model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int unsigned DEPTH     = 4;
    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] LIT_MASK  = 16'h00FF;
    localparam logic [15:0] LIT_MATCH = 16'h001A;
    localparam int unsigned EXP_LEN   = 96;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] literal;
        logic        has_lit;
        logic [15:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if ifc ();

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .LIT_MASK (LIT_MASK),
        .LIT_MATCH(LIT_MATCH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    logic [15:0] tb_mem [0:65535];
    always @(posedge clk) ifc.i_bus <= tb_mem[ifc.i_addr];

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   hs_words = 0;
    int   hs_total = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference: walk the instruction stream from a start address.
    task automatic build_expect(input logic [15:0] start);
        logic [15:0] pc;
        logic [15:0] w;
        exp_t        e;
        exp_q.delete();
        pc = start;
        for (int i = 0; i < EXP_LEN; i++) begin
            w = tb_mem[pc];
            if ((w & LIT_MASK) == LIT_MATCH) begin
                e = '{instr: w, literal: tb_mem[pc + 16'd1], has_lit: 1'b1, pc: pc};
                pc = pc + 16'd2;
            end else begin
                e = '{instr: w, literal: 16'h0000, has_lit: 1'b0, pc: pc};
                pc = pc + 16'd1;
            end
            exp_q.push_back(e);
        end
    endtask

    // Monitor: a handshake seen before a posedge is consumed at that posedge.
    always @(negedge clk) begin
        if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
            checks++;
            hs_total++;
            hs_words += ifc.out_has_lit ? 2 : 1;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL hs_unexpected: got instr=%h pc=%h want no handshake",
                         ifc.out_instr, ifc.out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if (ifc.out_instr !== mon_e.instr || ifc.out_literal !== mon_e.literal ||
                    ifc.out_has_lit !== mon_e.has_lit || ifc.out_pc !== mon_e.pc) begin
                    failures++;
                    $display("FAIL hs_%0d: got instr=%h lit=%h has=%b pc=%h want instr=%h lit=%h has=%b pc=%h",
                             hs_total, ifc.out_instr, ifc.out_literal, ifc.out_has_lit, ifc.out_pc,
                             mon_e.instr, mon_e.literal, mon_e.has_lit, mon_e.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        ifc.redirect = 1'b0;
        exp_q.delete();
        repeat (n) tick();
    endtask

    task automatic release_reset();
        build_expect(RESET_PC);
        rst = 1'b0;
    endtask

    // Returns just after the redirect posedge N with redirect deasserted.
    task automatic do_redirect(input logic [15:0] pc);
        ifc.out_ready   = 1'b1;
        ifc.redirect_pc = pc;
        ifc.redirect    = 1'b1;
        build_expect(pc);
        #1;
        chk("redirect_cycle_valid", 16'(ifc.out_valid), 16'd0);
        tick();
        ifc.redirect = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        ifc.redirect    = 1'b0;
        ifc.redirect_pc = 16'h0000;
        ifc.out_ready   = 1'b1;

        for (int a = 0; a < 65536; a++) begin
            if ($urandom_range(0, 3) == 0) tb_mem[a] = {8'($urandom), 8'h1A};
            else                           tb_mem[a] = 16'($urandom);
        end
        tb_mem[0]     = 16'hFF1A;
        tb_mem[1]     = 16'hAAAA;
        tb_mem[2]     = 16'hFF3A;
        tb_mem[3]     = 16'hFF3B;
        tb_mem[4]     = 16'hFF3F;
        tb_mem[16'h0010] = 16'h1234;

        repeat (3) tick();
        chk("rst_valid",   16'(ifc.out_valid),   16'd0);
        chk("rst_instr",   ifc.out_instr,        16'h0000);
        chk("rst_literal", ifc.out_literal,      16'h0000);
        chk("rst_pc",      ifc.out_pc,           16'h0000);
        chk("rst_has_lit", 16'(ifc.out_has_lit), 16'd0);
        chk("rst_i_addr",  ifc.i_addr,           RESET_PC);

        // Literal pair first: valid only after the third posedge.
        release_reset();
        tick();
        chk("t1_valid_p1", 16'(ifc.out_valid), 16'd0);
        tick();
        chk("t1_valid_p2", 16'(ifc.out_valid), 16'd0);
        tick();
        chk("t1_valid_p3", 16'(ifc.out_valid), 16'd1);
        chk("t1_instr",    ifc.out_instr,      16'hFF1A);
        chk("t1_literal",  ifc.out_literal,    16'hAAAA);
        hs_words = 0;
        repeat (16) tick();
        checks++;
        if (hs_words < 16 || hs_words > 17) begin
            failures++;
            $display("FAIL t1_throughput: got %0d words want 16..17", hs_words);
        end

        // Backpressure: FIFO fills, fetch stalls at address 4.
        apply_reset(2);
        ifc.out_ready = 1'b0;
        release_reset();
        repeat (10) tick();
        chk("t2_i_addr_stall", ifc.i_addr,          16'h0004);
        chk("t2_valid",        16'(ifc.out_valid),  16'd1);
        chk("t2_head_pc",      ifc.out_pc,          16'h0000);
        ifc.out_ready = 1'b1;
        repeat (12) tick();

        // Redirect while AAAA is still in flight.
        apply_reset(2);
        ifc.out_ready = 1'b1;
        release_reset();
        tick();
        tick();
        do_redirect(16'h0010);
        chk("t3_valid_n",   16'(ifc.out_valid), 16'd0);
        tick();
        chk("t3_valid_n1",  16'(ifc.out_valid), 16'd0);
        tick();
        chk("t3_valid_n2",  16'(ifc.out_valid), 16'd1);
        chk("t3_instr",     ifc.out_instr,      16'h1234);
        chk("t3_pc",        ifc.out_pc,         16'h0010);
        repeat (8) tick();

        // Redirect with a full FIFO and a stalled decoder.
        apply_reset(2);
        ifc.out_ready = 1'b0;
        release_reset();
        repeat (8) tick();
        chk("t4_full_valid", 16'(ifc.out_valid), 16'd1);
        do_redirect(16'($urandom_range(16'h0100, 16'hFF00)));
        for (int i = 0; i < 30; i++) begin
            ifc.out_ready = 1'($urandom_range(0, 1));
            tick();
        end

        // Literal pair straddling the address wrap.
        tb_mem[16'hFFFF] = 16'h001A;
        tb_mem[16'h0000] = 16'h5555;
        do_redirect(16'hFFFF);
        tick();
        tick();
        chk("t5_valid_n2",  16'(ifc.out_valid),   16'd0);
        tick();
        chk("t5_valid_n3",  16'(ifc.out_valid),   16'd1);
        chk("t5_instr",     ifc.out_instr,        16'h001A);
        chk("t5_literal",   ifc.out_literal,      16'h5555);
        chk("t5_pc",        ifc.out_pc,           16'hFFFF);
        chk("t5_has_lit",   16'(ifc.out_has_lit), 16'd1);
        repeat (6) tick();

        // Reset mid-operation with three buffered words.
        apply_reset(2);
        ifc.out_ready = 1'b0;
        release_reset();
        repeat (4) tick();
        chk("t6_pre_valid", 16'(ifc.out_valid), 16'd1);
        rst = 1'b1;
        exp_q.delete();
        ifc.out_ready = 1'b1;
        #1;
        chk("t6_rst_cycle_valid", 16'(ifc.out_valid), 16'd0);
        tick();
        chk("t6_i_addr",  ifc.i_addr,         RESET_PC);
        chk("t6_valid",   16'(ifc.out_valid), 16'd0);
        chk("t6_instr",   ifc.out_instr,      16'h0000);
        release_reset();
        repeat (20) tick();

        // Random redirects under random backpressure.
        for (int k = 0; k < 6; k++) begin
            do_redirect(16'($urandom));
            for (int i = 0; i < 25; i++) begin
                ifc.out_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end

        ifc.out_ready = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
